// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Sequences main-memory transactions for the control unit. It turns
//            level RD/WR requests into a four-phase strobe/ACK handshake with
//            memory, latches the read data, selects the bus-C source and
//            returns a one-cycle ACK (or error) to the control unit.
// Optional : MEM_ACCESS_CTRL_TIMEOUT_EN - when defined, a watchdog aborts a
//            request that receives no memory ACK within TIMEOUT_CYCLES cycles.
// Ports    :
//   mem_access_ctrl_CLOCK_50          clock, rising edge
//   mem_access_ctrl_RESET_InHigh      synchronous active-high reset
//   mem_access_ctrl_cc_rd_In/wr_In    request levels from the control unit
//   mem_access_ctrl_cc_addr_InBUS     address (BUS_A)
//   mem_access_ctrl_cc_wdata_InBUS    write data (BUS_B)
//   mem_access_ctrl_cc_ack_Out        one-cycle completion pulse
//   mem_access_ctrl_cc_error_Out      one-cycle error pulse (conflict/timeout)
//   mem_access_ctrl_cc_busy_Out       high whenever not idle
//   mem_access_ctrl_rdata_OutBUS      latched read data
//   mem_access_ctrl_busc_sel_Out      1 = memory data onto bus C, 0 = ALU
//   mem_access_ctrl_mem_rd_Out/wr_Out strobes to memory
//   mem_access_ctrl_mem_addr_OutBUS   registered address to memory
//   mem_access_ctrl_mem_wdata_OutBUS  registered write data to memory
//   mem_access_ctrl_mem_rdata_InBUS   read data from memory
//   mem_access_ctrl_mem_ack_In        memory acknowledge (level)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATAWIDTH_BUS     = 32,
    parameter int TIMEOUT_CYCLES    = 15,
    parameter int DATAWIDTH_TIMEOUT = 4
) (
    input  logic                     mem_access_ctrl_CLOCK_50,
    input  logic                     mem_access_ctrl_RESET_InHigh,
    input  logic                     mem_access_ctrl_cc_rd_In,
    input  logic                     mem_access_ctrl_cc_wr_In,
    input  logic [DATAWIDTH_BUS-1:0] mem_access_ctrl_cc_addr_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] mem_access_ctrl_cc_wdata_InBUS,
    output logic                     mem_access_ctrl_cc_ack_Out,
    output logic                     mem_access_ctrl_cc_error_Out,
    output logic                     mem_access_ctrl_cc_busy_Out,
    output logic [DATAWIDTH_BUS-1:0] mem_access_ctrl_rdata_OutBUS,
    output logic                     mem_access_ctrl_busc_sel_Out,
    output logic                     mem_access_ctrl_mem_rd_Out,
    output logic                     mem_access_ctrl_mem_wr_Out,
    output logic [DATAWIDTH_BUS-1:0] mem_access_ctrl_mem_addr_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] mem_access_ctrl_mem_wdata_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0] mem_access_ctrl_mem_rdata_InBUS,
    input  logic                     mem_access_ctrl_mem_ack_In
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_DONE    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_op_rd;      // 1 = current op is a read
    logic [DATAWIDTH_BUS-1:0] r_addr;
    logic [DATAWIDTH_BUS-1:0] r_wdata;
    logic [DATAWIDTH_BUS-1:0] r_rdata;

    logic w_start;
    logic w_conflict;
    logic w_tmo_hit;

    assign w_start    = mem_access_ctrl_cc_rd_In ^ mem_access_ctrl_cc_wr_In;
    assign w_conflict = mem_access_ctrl_cc_rd_In & mem_access_ctrl_cc_wr_In;

    // The counter width must be able to hold the timeout value.
    generate
        if ((2 ** DATAWIDTH_TIMEOUT) <= TIMEOUT_CYCLES) begin : g_param_check
            $error("DATAWIDTH_TIMEOUT too small for TIMEOUT_CYCLES");
        end
    endgenerate

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    // Counts completed REQ cycles without ACK. Abort on the edge that
    // completes the TIMEOUT_CYCLES-th such cycle, i.e. when the count
    // already stands at TIMEOUT_CYCLES-1.
    localparam logic [DATAWIDTH_TIMEOUT-1:0] C_TMO_LAST =
        DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [DATAWIDTH_TIMEOUT-1:0] r_tmo_cnt;

    always_ff @(posedge mem_access_ctrl_CLOCK_50) begin
        if (mem_access_ctrl_RESET_InHigh) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_REQ && !mem_access_ctrl_mem_ack_In) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == C_TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    // State register and datapath registers
    always_ff @(posedge mem_access_ctrl_CLOCK_50) begin
        if (mem_access_ctrl_RESET_InHigh) begin
            r_state <= ST_IDLE;
            r_op_rd <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            // Requests are only captured while idle; anything that changes
            // on the request bus while busy is ignored.
            if (r_state == ST_IDLE && w_start) begin
                r_op_rd <= mem_access_ctrl_cc_rd_In;
                r_addr  <= mem_access_ctrl_cc_addr_InBUS;
                r_wdata <= mem_access_ctrl_cc_wdata_InBUS;
            end
            if (r_state == ST_REQ && mem_access_ctrl_mem_ack_In && r_op_rd) begin
                r_rdata <= mem_access_ctrl_mem_rdata_InBUS;
            end
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_state_next                 = r_state;
        mem_access_ctrl_cc_ack_Out   = 1'b0;
        mem_access_ctrl_cc_error_Out = 1'b0;
        mem_access_ctrl_busc_sel_Out = 1'b0;
        mem_access_ctrl_mem_rd_Out   = 1'b0;
        mem_access_ctrl_mem_wr_Out   = 1'b0;
        mem_access_ctrl_cc_busy_Out  = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (w_conflict) begin
                    w_state_next = ST_ERR;
                end else if (w_start) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_access_ctrl_mem_rd_Out = r_op_rd;
                mem_access_ctrl_mem_wr_Out = ~r_op_rd;
                if (mem_access_ctrl_mem_ack_In) begin
                    w_state_next = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_DONE: begin
                mem_access_ctrl_cc_ack_Out   = 1'b1;
                mem_access_ctrl_busc_sel_Out = r_op_rd;
                w_state_next                 = ST_RELEASE;
            end
            ST_ERR: begin
                mem_access_ctrl_cc_error_Out = 1'b1;
                w_state_next                 = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Wait for both sides to drop so a held level cannot retrigger.
                if (!mem_access_ctrl_mem_ack_In && !mem_access_ctrl_cc_rd_In &&
                    !mem_access_ctrl_cc_wr_In) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_access_ctrl_rdata_OutBUS     = r_rdata;
    assign mem_access_ctrl_mem_addr_OutBUS  = r_addr;
    assign mem_access_ctrl_mem_wdata_OutBUS = r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences every main-memory transaction requested by the control unit (Centro_Control).
- Turns the control unit's level RD/WR requests into a four-phase strobe/ACK handshake with main memory.
- Latches read data and drives the bus-C source select (memory vs ALU).
- Returns a one-cycle ACK to the control unit. An optional watchdog aborts stalled accesses.
- Sits between Centro_Control, MAIN_MEMORY and the bus-C 64-to-32 mux; address comes from BUS_A, write data from BUS_B.

Parameters:
DATAWIDTH_BUS, 32, address/data width.
TIMEOUT_CYCLES, 15, REQ-state cycles without mem ACK before abort (optional feature only).
DATAWIDTH_TIMEOUT, 4, timeout counter width; must satisfy 2^DATAWIDTH_TIMEOUT > TIMEOUT_CYCLES.

Ports:
mem_access_ctrl_CLOCK_50  in  1  system clock, rising edge.
mem_access_ctrl_RESET_InHigh  in  1  synchronous active-high reset.
mem_access_ctrl_cc_rd_In  in  1  read request level from control unit.
mem_access_ctrl_cc_wr_In  in  1  write request level from control unit.
mem_access_ctrl_cc_addr_InBUS  in  DATAWIDTH_BUS  address (BUS_A).
mem_access_ctrl_cc_wdata_InBUS  in  DATAWIDTH_BUS  write data (BUS_B).
mem_access_ctrl_cc_ack_Out  out  1  one-cycle transaction-complete pulse to control unit.
mem_access_ctrl_cc_error_Out  out  1  one-cycle error pulse (conflict or timeout).
mem_access_ctrl_cc_busy_Out  out  1  high whenever state != IDLE.
mem_access_ctrl_rdata_OutBUS  out  DATAWIDTH_BUS  latched read data.
mem_access_ctrl_busc_sel_Out  out  1  1 = memory data onto bus C, 0 = ALU.
mem_access_ctrl_mem_rd_Out  out  1  read strobe to memory.
mem_access_ctrl_mem_wr_Out  out  1  write strobe to memory.
mem_access_ctrl_mem_addr_OutBUS  out  DATAWIDTH_BUS  registered address to memory.
mem_access_ctrl_mem_wdata_OutBUS  out  DATAWIDTH_BUS  registered write data to memory.
mem_access_ctrl_mem_rdata_InBUS  in  DATAWIDTH_BUS  read data from memory.
mem_access_ctrl_mem_ack_In  in  1  memory acknowledge (level).

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and has priority over everything.
- Reset effect on the next edge, including mid-transaction: state=IDLE, all outputs 0, rdata/addr/wdata registers 0, timeout counter 0, strobes dropped immediately.
- States: IDLE, REQ, DONE, RELEASE, ERR.
- IDLE:
  - rd XOR wr sampled high: latch addr/wdata and the op type, go to REQ. Strobe (mem_rd or mem_wr) is high from the following cycle.
  - rd AND wr both high: no memory access; go to ERR.
  - Neither high: stay in IDLE.
- REQ:
  - Strobe held; addr/wdata stable.
  - mem_ack_In sampled high: drop strobe; on a read, capture mem_rdata into rdata; go to DONE.
  - Otherwise the timeout counter increments (optional feature).
- DONE (exactly 1 cycle):
  - cc_ack_Out=1.
  - busc_sel_Out=1 only if the op was a read.
  - rdata valid and held until the next read completes.
  - Next state RELEASE.
- RELEASE:
  - Waits until mem_ack_In=0 AND cc_rd=cc_wr=0, then IDLE.
  - Prevents retriggering from held request levels.
- ERR (exactly 1 cycle): cc_error_Out=1, strobes 0, next state RELEASE.
- Latency: request sampled at edge N -> strobe high after N. mem_ack seen at edge M -> cc_ack high during cycle M..M+1. Minimum read turnaround is 3 cycles from request to ack pulse.
- Requests that change while the block is busy are ignored; addr/wdata are latched only in IDLE.
- mem_rd_Out and mem_wr_Out are never high simultaneously.
- cc_ack_Out and cc_error_Out are never high simultaneously.
- mem_ack_In high while in IDLE is ignored.
- busy is high in REQ, DONE, RELEASE and ERR.

Optional Feature:
MEM_ACCESS_CTRL_TIMEOUT_EN
- Defined:
  - Counter clears on entry to REQ.
  - When the counter reaches TIMEOUT_CYCLES with mem_ack still 0: drop strobe, go to ERR. This gives a 1-cycle error pulse, then RELEASE.
  - rdata is not updated on a timeout.
- Undefined:
  - No counter logic; REQ waits indefinitely for mem_ack.
  - cc_error_Out asserts only on an rd/wr conflict.

Test Plan:
1. Read: addr=0x00000010, rd=1; memory acks 2 cycles after strobe with data 0xDEADBEEF -> mem_rd high 2 cycles; then 1-cycle cc_ack with busc_sel=1 and rdata=0xDEADBEEF; mem_rd low; IDLE after rd and ack drop.
2. Write: addr=0x20, wdata=0x12345678, wr=1 -> mem_wr=1 with mem_addr=0x20 and mem_wdata=0x12345678 until ack; cc_ack pulse with busc_sel=0; rdata unchanged.
3. Conflict: rd=wr=1 in IDLE -> no strobe ever; cc_error 1 cycle; then RELEASE until both drop.
4. Timeout (macro defined, TIMEOUT_CYCLES=15): rd=1, ack never -> strobe drops after 15 REQ cycles; cc_error 1 cycle; no cc_ack. Macro undefined -> strobe still high after 100 cycles.
5. Reset mid-op: assert reset during REQ of a read -> after the next edge mem_rd=0, busy=0, rdata=0; a late ack produces no cc_ack.
6. Back-to-back: rd held high after cc_ack -> no second transaction until rd=0 for one cycle; re-asserting then starts a new read.
